// File: rtl/uart_arbiter.sv
// Multiplexes CHANNEL requesters onto one uart_comm FIFO pair using
// [channel][length][payload] framing, round-robin on transmit.
module uart_arbiter #(
  parameter int CHANNEL = 2,
  parameter int MAX_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CHANNEL-1:0]           send_req,
  input  logic [CHANNEL*4-1:0]         send_len,
  input  logic [CHANNEL*MAX_LEN*8-1:0] send_data,
  output logic [CHANNEL-1:0]           send_ack,
  output logic [CHANNEL-1:0]           recv_valid,
  output logic [3:0]                   recv_len,
  output logic [MAX_LEN*8-1:0]         recv_data,
  output logic                         uart_send_flag,
  output logic [7:0]                   uart_send_data,
  input  logic                         uart_sendable,
  output logic                         uart_recv_flag,
  input  logic [7:0]                   uart_recv_data,
  input  logic                         uart_receivable
);

  localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  typedef enum logic [2:0] {T_IDLE, T_HEAD, T_LEN, T_DATA, T_ACK} tx_state_t;
  typedef enum logic [1:0] {R_HEAD, R_LEN, R_DATA, R_DONE} rx_state_t;

  function automatic logic [3:0] clamp_len(input logic [7:0] len);
    if (int'(len) > MAX_LEN) return 4'(MAX_LEN);
    return len[3:0];
  endfunction

  tx_state_t        tx_state;
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    grant;
  logic [3:0]       tx_len;
  logic [3:0]       tx_idx;
  logic [7:0]       tx_byte;
  logic             tx_push;
  logic             tx_last;
  logic [CHANNEL-1:0] ack_vec;

  logic [2*CHANNEL-1:0] req_dbl;
  logic [CHANNEL-1:0]   req_rot;
  logic                 found;
  logic [CW-1:0]        pick;
  int                   off;
  int                   pick_i;

  // Rotate the requests so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    req_dbl = {send_req, send_req};
    req_rot = CHANNEL'(req_dbl >> ptr);
    found   = |req_rot;
    off     = 0;
    for (int k = CHANNEL - 1; k >= 0; k--) begin
      if (req_rot[k]) off = k;
    end
    pick_i = int'(ptr) + off;
    if (pick_i >= CHANNEL) pick_i = pick_i - CHANNEL;
    pick = CW'(pick_i);
  end

  always_comb begin
    tx_byte = 8'h00;
    case (tx_state)
      T_HEAD:  tx_byte = 8'(grant);
      T_LEN:   tx_byte = {4'h0, tx_len};
      T_DATA:  tx_byte = send_data[(int'(grant) * MAX_LEN + int'(tx_idx)) * 8 +: 8];
      default: tx_byte = 8'h00;
    endcase
  end

  // The push strobe must follow uart_sendable in the same cycle, so it is decoded, not registered.
  assign tx_push        = !RST && uart_sendable &&
                          (tx_state == T_HEAD || tx_state == T_LEN || tx_state == T_DATA);
  assign uart_send_flag = tx_push;
  assign uart_send_data = tx_push ? tx_byte : 8'h00;
  assign tx_last        = (tx_idx == tx_len - 4'd1);
  assign ack_vec        = CHANNEL'(1) << grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= T_IDLE;
      ptr      <= '0;
      grant    <= '0;
      tx_len   <= 4'd0;
      tx_idx   <= 4'd0;
      send_ack <= '0;
    end else begin
      send_ack <= '0;
      case (tx_state)
        T_IDLE: begin
          if (found) begin
            grant    <= pick;
            tx_len   <= clamp_len({4'h0, send_len[int'(pick) * 4 +: 4]});
            tx_state <= T_HEAD;
          end
        end
        T_HEAD: begin
          if (uart_sendable) tx_state <= T_LEN;
        end
        T_LEN: begin
          if (uart_sendable) begin
            tx_idx <= 4'd0;
            if (tx_len == 4'd0) begin
              send_ack <= ack_vec;
              tx_state <= T_ACK;
            end else begin
              tx_state <= T_DATA;
            end
          end
        end
        T_DATA: begin
          if (uart_sendable) begin
            if (tx_last) begin
              send_ack <= ack_vec;
              tx_state <= T_ACK;
            end else begin
              tx_idx <= tx_idx + 4'd1;
            end
          end
        end
        T_ACK: begin
          ptr      <= (int'(grant) == CHANNEL - 1) ? '0 : grant + CW'(1);
          tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  rx_state_t            rx_state;
  logic                 rx_gap;
  logic                 rx_pop;
  logic [7:0]           rx_ch;
  logic                 rx_drop;
  logic [3:0]           rx_len;
  logic [3:0]           rx_idx;
  logic [MAX_LEN*8-1:0] rx_buf;

  // A pop is always followed by one idle cycle so the FIFO head can advance.
  assign rx_pop         = !RST && uart_receivable && !rx_gap && (rx_state != R_DONE);
  assign uart_recv_flag = rx_pop;

  // Payload is staged here so a dropped frame never disturbs recv_data.
  always_ff @(posedge CLK) begin
    if (rx_pop && rx_state == R_DATA) rx_buf[int'(rx_idx) * 8 +: 8] <= uart_recv_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state   <= R_HEAD;
      rx_gap     <= 1'b0;
      rx_ch      <= 8'h00;
      rx_drop    <= 1'b0;
      rx_len     <= 4'd0;
      rx_idx     <= 4'd0;
      recv_valid <= '0;
      recv_len   <= 4'd0;
      recv_data  <= '0;
    end else begin
      rx_gap     <= rx_pop;
      recv_valid <= '0;
      case (rx_state)
        R_HEAD: begin
          if (rx_pop) begin
            rx_ch    <= uart_recv_data;
            rx_drop  <= (int'(uart_recv_data) >= CHANNEL);
            rx_state <= R_LEN;
          end
        end
        R_LEN: begin
          if (rx_pop) begin
            rx_len   <= clamp_len(uart_recv_data);
            rx_idx   <= 4'd0;
            rx_state <= (clamp_len(uart_recv_data) == 4'd0) ? R_DONE : R_DATA;
          end
        end
        R_DATA: begin
          if (rx_pop) begin
            if (rx_idx == rx_len - 4'd1) rx_state <= R_DONE;
            else rx_idx <= rx_idx + 4'd1;
          end
        end
        R_DONE: begin
          if (!rx_drop) begin
            recv_valid <= CHANNEL'(1) << rx_ch;
            recv_len   <= rx_len;
            for (int i = 0; i < MAX_LEN; i++) begin
              if (i < int'(rx_len)) recv_data[i*8 +: 8] <= rx_buf[i*8 +: 8];
            end
          end
          rx_state <= R_HEAD;
        end
        default: rx_state <= R_HEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: TX bytes/acks and RX deliveries are checked
// against scoreboard queues filled when the stimulus is applied.
module tb_uart_arbiter;
  localparam int CHANNEL = 2;
  localparam int MAX_LEN = 8;

  logic                         CLK = 1'b0;
  logic                         RST = 1'b1;
  logic [CHANNEL-1:0]           send_req = '0;
  logic [CHANNEL*4-1:0]         send_len = '0;
  logic [CHANNEL*MAX_LEN*8-1:0] send_data = '0;
  logic [CHANNEL-1:0]           send_ack;
  logic [CHANNEL-1:0]           recv_valid;
  logic [3:0]                   recv_len;
  logic [MAX_LEN*8-1:0]         recv_data;
  logic                         uart_send_flag;
  logic [7:0]                   uart_send_data;
  logic                         uart_sendable = 1'b1;
  logic                         uart_recv_flag;
  logic [7:0]                   uart_recv_data = 8'h00;
  logic                         uart_receivable = 1'b0;

  uart_arbiter #(.CHANNEL(CHANNEL), .MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RST(RST),
    .send_req(send_req), .send_len(send_len), .send_data(send_data), .send_ack(send_ack),
    .recv_valid(recv_valid), .recv_len(recv_len), .recv_data(recv_data),
    .uart_send_flag(uart_send_flag), .uart_send_data(uart_send_data), .uart_sendable(uart_sendable),
    .uart_recv_flag(uart_recv_flag), .uart_recv_data(uart_recv_data), .uart_receivable(uart_receivable)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [CHANNEL-1:0]   v;
    logic [3:0]           len;
    logic [MAX_LEN*8-1:0] data;
  } rx_exp_t;

  int                   vectors = 0;
  int                   miscompares = 0;
  int                   cyc = 0;
  int                   last_push_cyc = 0;
  logic                 prev_pop = 1'b0;
  logic                 pop_pend = 1'b0;
  logic [7:0]           tx_q[$];
  logic [CHANNEL-1:0]   ack_q[$];
  rx_exp_t              rx_q[$];
  rx_exp_t              mon_e;
  logic [7:0]           fifo[$];
  logic [MAX_LEN*8-1:0] rd_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Receive FIFO model: head is stable across the edge where the DUT pops it.
  always begin
    @(negedge CLK);
    pop_pend = uart_recv_flag;
    @(posedge CLK);
    #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    uart_receivable = (fifo.size() > 0);
    uart_recv_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  always @(negedge CLK) begin
    if (uart_send_flag) begin
      check("push_sendable", 64'(uart_sendable), 64'd1);
      if (tx_q.size() == 0) check("tx_extra_byte", 64'(tx_q.size()), 64'd1);
      else check("tx_byte", 64'(uart_send_data), 64'(tx_q.pop_front()));
      last_push_cyc = cyc;
    end
    if (|send_ack) begin
      check("ack_timing", 64'(cyc), 64'(last_push_cyc + 1));
      if (ack_q.size() == 0) check("ack_extra", 64'(ack_q.size()), 64'd1);
      else check("ack_vec", 64'(send_ack), 64'(ack_q.pop_front()));
    end
    if (|recv_valid) begin
      if (rx_q.size() == 0) check("rx_extra", 64'(rx_q.size()), 64'd1);
      else begin
        mon_e = rx_q.pop_front();
        check("recv_valid", 64'(recv_valid), 64'(mon_e.v));
        check("recv_len", 64'(recv_len), 64'(mon_e.len));
        check("recv_data", recv_data, mon_e.data);
      end
    end
    if (uart_recv_flag) begin
      check("pop_gap", 64'(prev_pop), 64'd0);
      check("pop_nonempty", 64'(uart_receivable), 64'd1);
    end
    prev_pop = uart_recv_flag;
  end

  task automatic exp_frame(input int ch, input int len, input logic [63:0] pl, input bit with_ack);
    tx_q.push_back(8'(ch));
    tx_q.push_back(8'(len));
    for (int i = 0; i < len; i++) tx_q.push_back(pl[i*8 +: 8]);
    if (with_ack) ack_q.push_back(CHANNEL'(1) << ch);
  endtask

  task automatic exp_rx(input int ch, input int len, input logic [63:0] pl);
    rx_exp_t e;
    for (int i = 0; i < len; i++) rd_model[i*8 +: 8] = pl[i*8 +: 8];
    e.v    = CHANNEL'(1) << ch;
    e.len  = 4'(len);
    e.data = rd_model;
    rx_q.push_back(e);
  endtask

  task automatic feed(input int n, input logic [95:0] bytes);
    for (int i = 0; i < n; i++) fifo.push_back(bytes[i*8 +: 8]);
  endtask

  task automatic wait_acks(input int n, output int last);
    int seen;
    seen = 0;
    last = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge CLK);
      if (|send_ack) begin
        seen++;
        last = cyc;
      end
    end
    check("ack_count", 64'(seen), 64'(n));
  endtask

  task automatic tx_drain();
    repeat (2) @(negedge CLK);
    check("tx_leftover", 64'(tx_q.size()), 64'd0);
    check("ack_leftover", 64'(ack_q.size()), 64'd0);
  endtask

  task automatic wait_rx();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (fifo.size() == 0 && rx_q.size() == 0) break;
    end
    repeat (6) @(negedge CLK);
    check("rx_fifo_left", 64'(fifo.size()), 64'd0);
    check("rx_exp_left", 64'(rx_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_send_ack"}, 64'(send_ack), 64'd0);
    check({tag, "_recv_valid"}, 64'(recv_valid), 64'd0);
    check({tag, "_recv_len"}, 64'(recv_len), 64'd0);
    check({tag, "_recv_data"}, recv_data, 64'd0);
    check({tag, "_send_flag"}, 64'(uart_send_flag), 64'd0);
    check({tag, "_send_data"}, 64'(uart_send_data), 64'd0);
    check({tag, "_recv_flag"}, 64'(uart_recv_flag), 64'd0);
  endtask

  initial begin
    int  ack_cyc;
    int  start;
    logic seen;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_idle("reset");

    // Both channels request continuously, one byte each: strict alternation from ch0.
    @(posedge CLK); #1;
    send_len = {4'd1, 4'd1};
    send_data = '0;
    send_data[7:0]   = 8'h5A;
    send_data[71:64] = 8'hA5;
    exp_frame(0, 1, 64'h5A, 1'b1);
    exp_frame(1, 1, 64'hA5, 1'b1);
    exp_frame(0, 1, 64'h5A, 1'b1);
    exp_frame(1, 1, 64'hA5, 1'b1);
    send_req = 2'b11;
    wait_acks(4, ack_cyc);
    @(posedge CLK); #1 send_req = 2'b00;
    tx_drain();

    // Single three-byte frame on ch0 with constant sendable.
    @(posedge CLK); #1;
    send_len = {4'd0, 4'd3};
    send_data = '0;
    send_data[23:0] = 24'h332211;
    exp_frame(0, 3, 64'h332211, 1'b1);
    start = cyc;
    send_req = 2'b01;
    wait_acks(1, ack_cyc);
    @(posedge CLK); #1 send_req = 2'b00;
    check("frame_time", 64'(ack_cyc - start), 64'd6);
    tx_drain();

    // Back-pressure: sendable toggles every cycle during a two-byte frame on ch1.
    @(posedge CLK); #1;
    send_len = {4'd2, 4'd0};
    send_data = '0;
    send_data[79:64] = 16'h8877;
    exp_frame(1, 2, 64'h8877, 1'b1);
    send_req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge CLK); #1 uart_sendable = ~uart_sendable;
      @(negedge CLK);
      if (send_ack[1]) seen = 1'b1;
    end
    @(posedge CLK); #1;
    send_req = 2'b00;
    uart_sendable = 1'b1;
    check("toggle_ack", 64'(seen), 64'd1);
    tx_drain();

    // Over-long length is clamped to MAX_LEN in the length byte and payload.
    @(posedge CLK); #1;
    send_len = {4'd0, 4'd12};
    send_data = '0;
    send_data[63:0] = 64'h0807060504030201;
    exp_frame(0, 8, 64'h0807060504030201, 1'b1);
    send_req = 2'b01;
    wait_acks(1, ack_cyc);
    @(posedge CLK); #1 send_req = 2'b00;
    tx_drain();

    // Receive path.
    exp_rx(1, 2, 64'hBBAA);
    feed(4, 96'hBBAA0201);
    wait_rx();

    feed(3, 96'hCC0105);
    wait_rx();
    check("drop_recv_len", 64'(recv_len), 64'd2);
    check("drop_recv_data", recv_data, rd_model);

    exp_rx(0, 0, 64'h0);
    feed(2, 96'h0000);
    wait_rx();

    exp_rx(0, 3, 64'hBEADDE);
    feed(5, 96'hBEADDE0300);
    wait_rx();

    exp_rx(1, 1, 64'h55);
    feed(3, 96'h550101);
    wait_rx();

    exp_rx(0, 8, 64'h1716151413121110);
    feed(10, {16'h0, 64'h1716151413121110, 8'h0C, 8'h00});
    wait_rx();

    // Reset in the middle of an eight-byte frame on ch1 (pointer is 1 here).
    @(posedge CLK); #1;
    send_len = {4'd8, 4'd0};
    send_data = '0;
    send_data[127:64] = 64'hF8F7F6F5F4F3F2F1;
    exp_frame(1, 8, 64'hF8F7F6F5F4F3F2F1, 1'b0);
    send_req = 2'b10;
    repeat (6) @(posedge CLK);
    #1;
    RST = 1'b1;
    send_req = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    check_idle("mid_reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    tx_q.delete();
    ack_q.delete();
    rd_model = '0;

    // After reset the pointer is back at 0, so ch0 wins over ch1.
    @(posedge CLK); #1;
    send_len = {4'd1, 4'd1};
    send_data = '0;
    send_data[7:0]   = 8'h3C;
    send_data[71:64] = 8'hC3;
    exp_frame(0, 1, 64'h3C, 1'b1);
    send_req = 2'b11;
    wait_acks(1, ack_cyc);
    @(posedge CLK); #1 send_req = 2'b00;
    tx_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
Shares one uart_comm instance between CHANNEL on-chip requesters, for example the CPU debug port and the loader.
- Transmit: each requester's message is framed as [channel byte][length byte][payload bytes]. Requesters are served round-robin.
- Receive: incoming frames are parsed and the payload is delivered to the addressed channel.
- Sits directly between the requesters and the uart_comm send/receive FIFO ports.

Parameters:
CHANNEL, 2, number of requesters (1..255).
MAX_LEN, 8, maximum payload bytes per frame (1..15).

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
send_req  input  CHANNEL  per-channel level request; must be held until send_ack
send_len  input  CHANNEL*4  per-channel payload length; channel c uses [c*4+:4]
send_data  input  CHANNEL*MAX_LEN*8  payload; byte i of channel c is [(c*MAX_LEN+i)*8+:8]
send_ack  output  CHANNEL  one-cycle pulse when channel's last frame byte has been pushed
recv_valid  output  CHANNEL  one-cycle pulse, frame delivered to that channel
recv_len  output  4  payload length of the last delivered frame
recv_data  output  MAX_LEN*8  payload of the last delivered frame; byte i at [i*8+:8]
uart_send_flag  output  1  push strobe to the uart_comm send FIFO
uart_send_data  output  8  byte to push
uart_sendable  input  1  uart_comm send FIFO not full
uart_recv_flag  output  1  pop strobe to the uart_comm receive FIFO
uart_recv_data  input  8  receive FIFO head byte, valid while uart_receivable
uart_receivable  input  1  uart_comm receive FIFO not empty

Behaviour:
Reset:
- All outputs 0.
- TX FSM to T_IDLE, RX FSM to R_HEAD.
- Round-robin pointer to 0.
- Reset mid-frame abandons the frame. Partial bytes already pushed are not recalled.

Length clamp:
- Effective length is min(len, MAX_LEN), for both TX and RX.
- The length byte sent is the clamped value, zero-extended.

TX FSM (T_IDLE, T_HEAD, T_LEN, T_DATA, T_ACK):
- T_IDLE: grant the first requesting channel at or after the pointer, wrapping modulo CHANNEL. Latch the grant index and clamped length. Go to T_HEAD. No request means stay.
- T_HEAD, T_LEN, T_DATA: push exactly one byte per cycle, only in cycles where uart_sendable=1. uart_send_flag is high only in those cycles.
  - T_HEAD pushes the grant index.
  - T_LEN pushes the length.
  - T_DATA pushes bytes 0..len-1.
- Length 0: T_LEN goes straight to T_ACK.
- T_ACK: pulse send_ack[grant] for one cycle. Set pointer to (grant+1) mod CHANNEL. Return to T_IDLE.
- A grant remains latched if send_req drops mid-frame. send_data/send_len are sampled when each byte is pushed, so the requester must hold them stable until ack.
- Minimum frame time is len+4 cycles when uart_sendable is constantly high.

RX FSM (R_HEAD, R_LEN, R_DATA, R_DONE):
- Pop rule:
  - A byte is consumed by asserting uart_recv_flag for one cycle while uart_receivable=1. uart_recv_data is sampled in that same cycle.
  - After any pop, the next cycle is a forced gap with no pop, so the FIFO head can update. Maximum rate is one byte per 2 cycles.
- R_HEAD: latch the channel byte. A value >= CHANNEL marks the frame as drop.
- R_LEN: latch the clamped length.
  - Bytes beyond the clamp are not expected. The sender is this same block or a compliant host.
  - A length of 0 goes to R_DONE.
- R_DATA: store bytes into recv_data in order. After len bytes, go to R_DONE.
- R_DONE: if not drop, pulse recv_valid[ch] for one cycle and update recv_len. Return to R_HEAD. Dropped frames produce no pulse and leave recv_len/recv_data unchanged.
- recv_data and recv_len hold their values until the next delivered frame.
- Unused high bytes of recv_data retain their previous contents.
- TX and RX run fully independently. Simultaneous send and receive is allowed.

Test Plan:
- CHANNEL=2, ch0 len=3 data 11,22,33, uart_sendable=1 -> pushes 00,03,11,22,33 on consecutive cycles; send_ack[0] pulses one cycle later; send_ack[1]=0.
- Both channels request continuously, each len=1 -> frame order ch0,ch1,ch0,ch1; every send_ack pulse alternates.
- uart_sendable toggles 1,0 every cycle during a len=2 frame -> same 4 bytes pushed, no push in any cycle with sendable=0.
- Feed FIFO bytes 01,02,AA,BB -> recv_valid[1] single pulse, recv_len=2, recv_data[15:0]=BBAA; uart_recv_flag never asserted on two consecutive cycles.
- Feed 05,01,CC then 00,00 -> first frame dropped with no pulse; then recv_valid[0] pulses with recv_len=0.
- Assert RST during T_DATA of a len=8 frame -> next cycle all outputs 0; the next request restarts from the header byte with the pointer at 0.
